// File: rtl/square_iter.sv
// Iterative MSB-first shift-add squarer, Q = A*A, one root bit per cycle.
// Define SQUARE_ITER_ROOTCHECK_EN to add the T input, root_ok output and CHECK state.
module square_iter #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2 * IN_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic [IN_W-1:0]  A,
`ifdef SQUARE_ITER_ROOTCHECK_EN
  input  logic [OUT_W-1:0] T,
  output logic             root_ok,
`endif
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] Q
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
`ifdef SQUARE_ITER_ROOTCHECK_EN
    S_CHECK = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  opa_q, opa_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] q_q, q_d;
  logic [OUT_W-1:0] opa_ext;

  assign opa_ext = OUT_W'(opa_q);

`ifdef SQUARE_ITER_ROOTCHECK_EN
  logic [OUT_W-1:0] t_q, t_d;
  logic             ok_q, ok_d;
  logic [OUT_W:0]   nxt;

  // (A+1)^2 = A^2 + 2A + 1, one extra bit so it never wraps
  assign nxt = {1'b0, acc_q}
             + ((OUT_W+1)'(opa_q) << 1)
             + (OUT_W+1)'(1);
`endif

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
`ifdef SQUARE_ITER_ROOTCHECK_EN
    t_d     = t_q;
    ok_d    = ok_q;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          opa_d   = A;
          acc_d   = '0;
          cnt_d   = CNT_W'(IN_W - 1);
`ifdef SQUARE_ITER_ROOTCHECK_EN
          t_d     = T;
`endif
          state_d = S_BUSY;
        end
      end
      (state_q == S_BUSY): begin
        acc_d = (acc_q << 1)
              + (opa_q[cnt_q] ? opa_ext : '0);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          q_d     = acc_d;
`ifdef SQUARE_ITER_ROOTCHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SQUARE_ITER_ROOTCHECK_EN
      (state_q == S_CHECK): begin
        ok_d    = (acc_q <= t_q)
               && ({1'b0, t_q} < nxt);
        state_d = S_DONE;
      end
`endif
      (state_q == S_DONE): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
`ifdef SQUARE_ITER_ROOTCHECK_EN
      t_q     <= '0;
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
`ifdef SQUARE_ITER_ROOTCHECK_EN
      t_q     <= t_d;
      ok_q    <= ok_d;
`endif
    end
  end

`ifdef SQUARE_ITER_ROOTCHECK_EN
  assign busy    = (state_q == S_BUSY)
                || (state_q == S_CHECK);
  assign root_ok = ok_q;
`else
  assign busy    = (state_q == S_BUSY);
`endif
  assign done    = (state_q == S_DONE);
  assign Q       = q_q;

endmodule

// File: doc/square_iter.md
Name: square_iter

Overview:
- Iterative shift-add squarer: the inverse of the square-root unit. Takes a root A and returns Q = A*A.
- Uses the same start/operand/result style as the square-root unit, so the two can be chained for round-trip checks.
- One multiplicand bit is processed per cycle, MSB first, so no hardware multiplier is inferred.
- Sits beside the square-root unit in the FPGA datapath. It is also used in benches as a golden back-check of root results.

Parameters:
- IN_W, 8, width of root operand A.
- OUT_W, 2*IN_W, width of square result Q. Must be ≥ 2*IN_W; extra MSBs are always 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_  in  1  reset, synchronous, active-low.
- start  in  1  request pulse/level; sampled only in IDLE.
- A  in  IN_W  root operand; latched on the accepted start.
- busy  out  1  high while an operation is in flight (BUSY and CHECK states).
- done  out  1  one-cycle pulse when Q is updated.
- Q  out  OUT_W  square result; holds until the next completion.

Behaviour:
- Reset (rst_=0 at a rising edge):
  - state=IDLE, busy=0, done=0, Q=0, internal acc/count/operand=0.
  - Takes priority over all other inputs.
  - Mid-operation reset aborts the operation: no done pulse, and Q is cleared to 0.
- States: IDLE, BUSY, (CHECK only with the optional feature), DONE.
- IDLE:
  - start=1 at edge k: latch A into opA, acc=0, cnt=IN_W-1, go to BUSY.
  - start=0: stay in IDLE.
- BUSY, one edge per bit, i=cnt from IN_W-1 down to 0:
  - acc = (acc<<1) + (opA[i] ? opA : 0), computed at OUT_W width with no overflow possible.
  - cnt decrements each edge.
  - On the edge where cnt==0: Q = final acc, go to DONE (or CHECK if the feature is enabled).
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally to IDLE.
- Latency without the feature:
  - start accepted at edge k; Q valid and done=1 after edge k+IN_W (9 edges to the done edge for IN_W=8).
  - Next start can be accepted at edge k+IN_W+2.
- start while BUSY/CHECK/DONE is ignored: no queueing, operand not re-latched.
- Holding start high continuously gives back-to-back operations, one every IN_W+2 cycles.
- A may change freely after acceptance; only the latched opA is used.
- Boundaries:
  - A=0 gives Q=0 with full latency (no early exit).
  - A=2^IN_W-1 gives Q=(2^IN_W-1)^2, e.g. 65025 for IN_W=8.

Optional Feature:
- Macro: SQUARE_ITER_ROOTCHECK_EN.
- With the macro defined:
  - Extra input T (OUT_W bits), latched with A on start.
  - Extra output root_ok (1 bit), reset 0, updated together with done.
  - After BUSY the FSM enters CHECK for one cycle and computes nxt = Q + 2*opA + 1, i.e. (A+1)^2, at OUT_W+1 bits.
  - root_ok = (Q ≤ T) && (T < nxt), meaning A == floor(sqrt(T)).
  - Total latency grows by 1 cycle: done after edge k+IN_W+1; back-to-back period IN_W+3.
- Without the macro: no T, no root_ok, no CHECK state, timing exactly as in Behaviour.

Test Plan:
- Reset, then A=0, start=1 for one cycle: done pulses once after edge k+8, Q=0; busy high for 8 cycles, then done.
- A=12: Q=144. A=0x80: Q=16384. A=255: Q=65025. Each result holds after done falls and until the next done.
- start held high with A=3 and then A=5 on consecutive accepts: Q=9 then Q=25, done pulses spaced 10 cycles apart; start pulses during busy produce no extra operations.
- Start A=200, drive rst_=0 at the 4th BUSY cycle for one edge: no done pulse, Q=0, busy=0 next cycle; a fresh start with A=7 then gives Q=49.
- SQUARE_ITER_ROOTCHECK_EN defined:
  - A=12, T=150: root_ok=1.
  - A=12, T=169: root_ok=0.
  - A=13, T=169: root_ok=1.
  - A=255, T=65535: root_ok=1.
  - done arrives at edge k+9.
